// File: rtl/parity_link_arbiter.sv
// parity_link_arbiter
//   Shares one serial, parity-protected line between two parallel-word
//   requesters. Requesters are arbitrated round-robin. The granted word is
//   captured through a valid/ready handshake and sent as one frame:
//   start bit (0), data LSB-first, running-parity bit, stop bit (1).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | line idle high; grant and capture a word if any valid is high
//   S_START  | start bit (0) on the line
//   S_DATA   | DATA_W data bits, LSB first, parity accumulating
//   S_PARITY | accumulated parity bit on the line
//   S_STOP   | stop bit (1) on the line; next cycle is idle
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   req0_valid/data/ready   requester 0 handshake (ready: one-cycle capture pulse)
//   req1_valid/data/ready   requester 1 handshake
//   ser_out                 serial line, idles high
//   busy                    high while a frame is on the line
//   grant_id                owner of the current or most recent frame
module parity_link_arbiter #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              grant_id
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic              par;
    logic [CNT_W-1:0]  cnt;
    logic              last;

    logic any_valid;
    logic gnt_sel;
    logic gnt_fire;

    // Under contention the requester that did not win last time is chosen.
    // The ready pulse is the combinational grant so that the capture, the
    // pulse and the transition to START all happen in the same IDLE cycle.
    // Gating with rst_n keeps a held valid from producing a pulse while the
    // block is in reset.
    assign any_valid  = req0_valid | req1_valid;
    assign gnt_sel    = (req0_valid & req1_valid) ? ~last : req1_valid;
    assign gnt_fire   = rst_n & (state == S_IDLE) & any_valid;
    assign req0_ready = gnt_fire & ~gnt_sel;
    assign req1_ready = gnt_fire & gnt_sel;

    // ser_out/busy are loaded with the value belonging to the state being
    // entered, so the line is registered yet lines up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            par       <= PARITY_ODD;
            cnt       <= '0;
            last      <= 1'b1;
            ser_out   <= 1'b1;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ser_out <= 1'b1;
                    busy    <= 1'b0;
                    if (gnt_fire) begin
                        shift_reg <= gnt_sel ? req1_data : req0_data;
                        last      <= gnt_sel;
                        grant_id  <= gnt_sel;
                        par       <= PARITY_ODD;
                        cnt       <= '0;
                        ser_out   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    ser_out   <= shift_reg[0];
                    par       <= par ^ shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    cnt       <= '0;
                    state     <= S_DATA;
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        // par already includes every data bit here
                        ser_out <= par;
                        state   <= S_PARITY;
                    end else begin
                        ser_out   <= shift_reg[0];
                        par       <= par ^ shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        cnt       <= cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    ser_out <= 1'b1;
                    state   <= S_STOP;
                end
                S_STOP: begin
                    ser_out <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    ser_out <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_link_arbiter.sv
// Bench for parity_link_arbiter: an even-parity and an odd-parity instance
// share all inputs. A frame-level model (queues of expected line bits built
// from the frame format) predicts every cycle's outputs.
module tb_parity_link_arbiter;

    logic       clk;
    logic       rst_n;
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic       r0_e, r1_e, ser_e, busy_e, gid_e;
    logic       r0_o, r1_o, ser_o, busy_o, gid_o;

    parity_link_arbiter #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0_e),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1_e),
        .ser_out(ser_e), .busy(busy_e), .grant_id(gid_e)
    );

    parity_link_arbiter #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0_o),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1_o),
        .ser_out(ser_o), .busy(busy_o), .grant_id(gid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    logic m_last, m_gid;
    logic qe[$];
    logic qo[$];
    logic ack0, ack1;
    logic obs_ser_e, obs_ser_o, obs_busy, obs_r0, obs_r1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    function automatic void push_frame(input logic [7:0] d);
        qe.push_back(1'b0);
        qo.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            qe.push_back(d[i]);
            qo.push_back(d[i]);
        end
        qe.push_back(^d);
        qo.push_back(~^d);
        qe.push_back(1'b1);
        qo.push_back(1'b1);
    endfunction

    function automatic void model_reset();
        qe.delete();
        qo.delete();
        m_last = 1'b1;
        m_gid  = 1'b0;
        ack0   = 1'b0;
        ack1   = 1'b0;
    endfunction

    // Entered at posedge+2 with inputs already set; checks at posedge+3,
    // advances the model, returns at the next posedge+2.
    task automatic step();
        logic es, eo, eb, er0, er1, g;
        #1;
        if (qe.size() > 0) begin
            es = qe[0]; eo = qo[0]; eb = 1'b1;
        end else begin
            es = 1'b1; eo = 1'b1; eb = 1'b0;
        end
        er0 = 1'b0; er1 = 1'b0; g = 1'b0;
        if (qe.size() == 0 && (v0 || v1)) begin
            g   = (v0 && v1) ? ~m_last : v1;
            er0 = ~g;
            er1 = g;
        end
        chk("ser_even", ser_e, es);
        chk("ser_odd", ser_o, eo);
        chk("busy_even", busy_e, eb);
        chk("busy_odd", busy_o, eb);
        chk("ready0_even", r0_e, er0);
        chk("ready1_even", r1_e, er1);
        chk("ready0_odd", r0_o, er0);
        chk("ready1_odd", r1_o, er1);
        chk("grant_id_even", gid_e, m_gid);
        chk("grant_id_odd", gid_o, m_gid);
        chk("ready_exclusive", r0_e & r1_e, 1'b0);
        obs_ser_e = ser_e;
        obs_ser_o = ser_o;
        obs_busy  = busy_e;
        obs_r0    = r0_e;
        obs_r1    = r1_e;
        ack0      = er0;
        ack1      = er1;
        if (qe.size() > 0) begin
            void'(qe.pop_front());
            void'(qo.pop_front());
        end
        if (er0 || er1) begin
            push_frame(g ? d1 : d0);
            m_last = g;
            m_gid  = g;
        end
        cyc++;
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        chk("rst_ser_even", ser_e, 1'b1);
        chk("rst_ser_odd", ser_o, 1'b1);
        chk("rst_busy", busy_e, 1'b0);
        chk("rst_ready0", r0_e, 1'b0);
        chk("rst_ready1", r1_e, 1'b0);
        chk("rst_grant_id", gid_e, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Sends one req0/req1 word alone and records the 11 line bits.
    logic [10:0] cap_e, cap_o;
    int          busy_cnt;
    task automatic send_one(input logic who, input logic [7:0] d);
        if (who) begin v1 = 1'b1; d1 = d; end
        else begin v0 = 1'b1; d0 = d; end
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            cap_e[i] = obs_ser_e;
            cap_o[i] = obs_ser_o;
            if (obs_busy) busy_cnt++;
        end
        step();
        if (obs_busy) busy_cnt++;
    endtask

    int   gcyc[$];
    logic gids[$];

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset_dut();

        // idle, no requests
        repeat (20) step();

        // req0 alone, 0xA5
        send_one(1'b0, 8'hA5);
        chk("a5_sequence", cap_e, 11'b10101001010);
        chk("a5_busy_cycles", busy_cnt, 11);
        chk("a5_grant_id", gid_e, 1'b0);

        // req1 alone, 0x07: parity 1 even, 0 odd
        send_one(1'b1, 8'h07);
        chk("x07_parity_even", cap_e[9], 1'b1);
        chk("x07_parity_odd", cap_o[9], 1'b0);
        chk("x07_grant_id", gid_e, 1'b1);

        // edge patterns
        send_one(1'b0, 8'h00);
        chk("x00_parity_even", cap_e[9], 1'b0);
        chk("x00_parity_odd", cap_o[9], 1'b1);
        send_one(1'b0, 8'hFF);
        chk("xff_parity_even", cap_e[9], 1'b0);
        chk("xff_parity_odd", cap_o[9], 1'b1);

        // both held from reset: alternate, 12 cycles apart
        reset_dut();
        v0 = 1'b1; d0 = 8'h01; v1 = 1'b1; d1 = 8'h80;
        for (int i = 0; i < 48; i++) begin
            step();
            if (obs_r0 || obs_r1) begin
                gcyc.push_back(cyc);
                gids.push_back(obs_r1);
            end
        end
        chk("contention_grants", gcyc.size(), 4);
        for (int k = 0; k < gids.size(); k++)
            chk("contention_order", gids[k], k % 2);
        for (int k = 1; k < gcyc.size(); k++)
            chk("contention_spacing", gcyc[k] - gcyc[k-1], 12);
        v0 = 1'b0; v1 = 1'b0;
        repeat (12) step();

        // req1-only frame then contention: req0 next
        reset_dut();
        send_one(1'b1, 8'h3A);
        v0 = 1'b1; d0 = 8'h5C; v1 = 1'b1; d1 = 8'hC3;
        step();
        chk("rr_pointer_req0", obs_r0, 1'b1);
        v0 = 1'b0; v1 = 1'b0;
        repeat (12) step();

        // async reset mid-frame, then requester 0 preferred
        v0 = 1'b1; d0 = 8'h3C;
        step();
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_ser_even", ser_e, 1'b1);
        chk("midrst_ser_odd", ser_o, 1'b1);
        chk("midrst_busy", busy_e, 1'b0);
        chk("midrst_ready0", r0_e, 1'b0);
        #1;
        rst_n = 1'b1;
        model_reset();
        v1 = 1'b1; d1 = 8'h99;
        step();
        chk("post_reset_req0_first", obs_r0, 1'b1);
        v0 = 1'b0; v1 = 1'b0;
        repeat (12) step();

        // randomized traffic; a requester holds its word until captured
        for (int i = 0; i < 400; i++) begin
            if (!v0 || ack0) begin
                v0 = ($urandom_range(0, 2) == 0);
                d0 = 8'($urandom);
            end
            if (!v1 || ack1) begin
                v1 = ($urandom_range(0, 2) == 0);
                d1 = 8'($urandom);
            end
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (14) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
